keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter NROWS, default 4, meaning the number of keypad rows driven (2..8).
REQ-002 The block SHALL have parameter NCOLS, default 4, meaning the number of keypad columns sensed (2..8).
REQ-003 The block SHALL have parameter SCAN_DIV, default 24000, meaning clk cycles each row is driven while scanning (>=4).
REQ-004 The block SHALL have parameter DEB_CYCLES, default 48000, meaning clk cycles of stable input required to accept a press or a release (>=2).
REQ-005 The block SHALL have parameter HIST_DEPTH, default 2, meaning the number of accepted key codes retained (>=1).
REQ-006 The block SHALL have parameter REPEAT_CYCLES, default 24000000, meaning the auto-repeat period in clk cycles (used only under REQ-028).
REQ-007 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-008 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-009 The block SHALL have port cols, input, NCOLS bits, asynchronous column sense, active-low (pull-ups).
REQ-010 The block SHALL have port rows, output, NROWS bits, row drive, active-low, exactly one bit low at all times.
REQ-011 The block SHALL have port key_code, output, KW=$clog2(NROWS*NCOLS) bits, the last accepted key, encoded row*NCOLS+col.
REQ-012 The block SHALL have port key_valid, output, 1 bit, a one-cycle pulse on each accepted press (and on each repeat).
REQ-013 The block SHALL have port key_held, output, 1 bit, high while in state HELD or RELEASE.
REQ-014 The block SHALL have port hist, output, HIST_DEPTH*KW bits, the accepted-code history with the newest code in bits [KW-1:0].

Function
REQ-015 cols SHALL pass through a 2-flop synchronizer per bit; all decisions SHALL use the synchronized value (2-cycle latency).
REQ-016 The FSM SHALL have states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-017 In SCAN, the low row SHALL advance row r -> r+1 every SCAN_DIV cycles, wrapping from NROWS-1 to 0.
REQ-018 In SCAN, any synchronized column low SHALL freeze the row, latch candidate col = lowest-index low column, clear the counter, and enter DEBOUNCE.
REQ-019 In DEBOUNCE, if the lowest low column equals the candidate for DEB_CYCLES consecutive cycles, the FSM SHALL enter HELD.
REQ-020 In DEBOUNCE, if the lowest low column changes or all columns are high, the FSM SHALL return to SCAN with the row advance counter restarted on the same row.
REQ-021 On entry to HELD, key_code SHALL update, key_valid SHALL pulse for exactly one cycle, and hist SHALL shift left by KW with the new code inserted in the LSBs and the oldest code discarded.
REQ-022 In HELD, all columns high SHALL enter RELEASE with the counter cleared; presses on other rows SHALL be ignored because the row stays frozen.
REQ-023 In RELEASE, DEB_CYCLES consecutive all-high cycles SHALL return the FSM to SCAN at the next row; any column low SHALL return it to HELD without a new key_valid.
REQ-024 Multiple simultaneous keys in the frozen row SHALL resolve to the lowest column index.
REQ-025 The counters SHALL be wide enough for max(SCAN_DIV, DEB_CYCLES, REPEAT_CYCLES) and SHALL never wrap.

Reset
REQ-026 While reset is high: state=SCAN, rows=~1 (row 0 low), counters=0, synchronizer flops=all-ones, key_code=0, key_valid=0, key_held=0, hist=0.
REQ-027 Reset asserted mid-operation, including during a key_valid cycle, SHALL take effect immediately; no pulse SHALL be emitted after release of reset until a new full debounce completes.

Configuration
REQ-028 Macro KEYPAD_REPEAT_EN: when defined, after REPEAT_CYCLES continuous cycles in HELD, key_valid SHALL pulse again and hist SHALL shift in the same code, repeating every REPEAT_CYCLES while held; the repeat timer SHALL be cleared on entry to HELD, including re-entry from RELEASE.
REQ-029 Macro KEYPAD_REPEAT_EN: when undefined, exactly one key_valid SHALL occur per press, and no repeat logic SHALL be synthesized.

Verification (NROWS=4, NCOLS=4, SCAN_DIV=4, DEB_CYCLES=8, HIST_DEPTH=2, REPEAT_CYCLES=40)
REQ-030 Reset then idle 64 cycles -> rows cycles 1110,1101,1011,0111 with 4 cycles each; key_valid stays 0.
REQ-031 Hold col1 low when row2 is active, for 20 cycles -> one key_valid, key_code=9, hist[3:0]=9, key_held=1; release -> key_held falls 8 cycles after sync, scanning resumes at row3.
REQ-032 Press code 9 then code 6 -> hist=8'h96.
REQ-033 Glitch col0 low for 5 cycles -> return to SCAN, no key_valid; bounce of 3 cycles high during HELD -> no second pulse.
REQ-034 Cols 0 and 2 low together on row1 -> key_code=4.
REQ-035 Under KEYPAD_REPEAT_EN, hold code 9 for 100 cycles after acceptance -> pulses at +0, +40 and +80; without the macro, exactly 1 pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// Row-scanning keypad controller: column synchronizer, press/release debounce, accepted-code history.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int NROWS         = 4,
   parameter int NCOLS         = 4,
   parameter int SCAN_DIV      = 24000,
   parameter int DEB_CYCLES    = 48000,
   parameter int HIST_DEPTH    = 2,
   parameter int REPEAT_CYCLES = 24000000
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [NCOLS-1:0]                          cols,
   output logic [NROWS-1:0]                          rows,
   output logic [$clog2(NROWS*NCOLS)-1:0]            key_code,
   output logic                                      key_valid,
   output logic                                      key_held,
   output logic [HIST_DEPTH*$clog2(NROWS*NCOLS)-1:0] hist
);
   localparam int KW    = $clog2(NROWS*NCOLS);
   localparam int RW    = $clog2(NROWS);
   localparam int CLW   = $clog2(NCOLS);
   localparam int HW    = HIST_DEPTH*KW;
   localparam int MAX_A = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
   localparam int CMAX  = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
   localparam int CW    = $clog2(CMAX + 1);
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(NROWS - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;

   state_e           state_q, state_d;
   logic [NCOLS-1:0] sync1_q, sync2_q;
   logic [RW-1:0]    row_q, row_d, row_next;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CLW-1:0]   cand_q, cand_d, low_col;
   logic [KW-1:0]    key_code_q, key_code_d, cand_code;
   logic             key_valid_q, key_valid_d;
   logic [HW-1:0]    hist_q, hist_d;
   logic             any_low;
`ifdef KEYPAD_REPEAT_EN
   localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);
   logic [CW-1:0]    rpt_q, rpt_d;
`endif

   function automatic logic [CLW-1:0] lowest_low(input logic [NCOLS-1:0] c);
      lowest_low = '0;
      for (int i = NCOLS - 1; i >= 0; i--) begin
         if (!c[i]) lowest_low = CLW'(i);
      end
   endfunction

   assign any_low   = ~&sync2_q;
   assign low_col   = lowest_low(sync2_q);
   assign row_next  = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
   assign cand_code = KW'(row_q) * KW'(NCOLS) + KW'(cand_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= cols;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      cnt_d       = cnt_q;
      cand_d      = cand_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      hist_d      = hist_q;
`ifdef KEYPAD_REPEAT_EN
      rpt_d       = '0;
`endif
      case (state_q)
         SCAN: begin
            // A press has priority over the row advance so the row stays on the key just seen.
            if (any_low) begin
               state_d = DEBOUNCE;
               cand_d  = low_col;
               cnt_d   = '0;
            end else if (cnt_q >= SCAN_LAST) begin
               row_d = row_next;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DEBOUNCE: begin
            if (!any_low || low_col != cand_q) begin
               state_d = SCAN;
               cnt_d   = '0;
            end else if (cnt_q >= DEB_LAST) begin
               state_d     = HELD;
               key_valid_d = 1'b1;
               key_code_d  = cand_code;
               hist_d      = (hist_q << KW) | HW'(cand_code);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HELD: begin
            if (!any_low) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rpt_q >= RPT_LAST) begin
               key_valid_d = 1'b1;
               hist_d      = (hist_q << KW) | HW'(key_code_q);
            end else begin
               rpt_d = rpt_q + CW'(1);
            end
`endif
         end
         RELEASE: begin
            // Re-entering HELD here is a bounce, not a new press, so no key_valid.
            if (any_low) begin
               state_d = HELD;
            end else if (cnt_q >= DEB_LAST) begin
               state_d = SCAN;
               row_d   = row_next;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = SCAN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SCAN;
         row_q       <= '0;
         cnt_q       <= '0;
         cand_q      <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         hist_q      <= '0;
`ifdef KEYPAD_REPEAT_EN
         rpt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         hist_q      <= hist_d;
`ifdef KEYPAD_REPEAT_EN
         rpt_q       <= rpt_d;
`endif
      end
   end

   assign rows      = ~(NROWS'(1) << row_q);
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = (state_q == HELD) || (state_q == RELEASE);
   assign hist      = hist_q;

endmodule
